addsub_arbiter: RTL and testbench
=================================

ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of requester ports.
REQ-002 The block SHALL have parameter SETTLE, default 1, legal range 1..15, giving the cycles allowed for the shared add/sub unit to settle.
REQ-003 The block SHALL have these ports, in this order:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  NREQ  per-requester request level.
- sub  in  NREQ  per-requester operation select: 1 = subtract, 0 = add.
- op_a  in  16*NREQ  packed first operand; requester k at [16k+15:16k].
- op_b  in  16*NREQ  packed second operand; same packing as op_a.
- err_clr  in  NREQ  per-requester clear strobe for err_sticky.
- gnt  out  NREQ  one-hot, one-cycle acceptance pulse.
- rsp_valid  out  NREQ  one-hot, one-cycle result pulse to the owning requester.
- rsp_data  out  16  captured result (scale in [15:13], mantissa in [12:0]).
- rsp_cout  out  1  captured carry out.
- rsp_invalid  out  1  captured overflow/invalid flag.
- err_sticky  out  NREQ  per-requester sticky invalid flag.
- busy  out  1  high whenever the block is not in IDLE.
- au_sub  out  1  operation select to the shared add/sub unit.
- au_in1  out  16  first operand to the unit.
- au_in2  out  16  second operand to the unit.
- au_cin  out  1  carry in to the unit.
- au_out  in  16  result from the unit.
- au_cout  in  1  carry out from the unit.
- au_invalid  in  1  invalid flag from the unit.

Function
REQ-004 The block SHALL use an FSM with states IDLE, WAIT and DONE, each held in registers.
REQ-005 In IDLE with req==0, the block SHALL remain in IDLE and hold all outputs except busy, which is 0.
REQ-006 In IDLE with req!=0, the block SHALL select requester k round-robin: search from (last+1) mod NREQ upward with wrap-around, where last is the most recently served index.
REQ-007 At that edge, the block SHALL:
- register sub[k], op_a[k] and op_b[k] into au_sub, au_in1 and au_in2;
- load a 4-bit counter with SETTLE;
- store k;
- drive gnt[k]=1 for exactly the next cycle;
- enter WAIT.
REQ-008 A requester SHALL hold req, sub and operands stable until it sees gnt, then drop req. The block SHALL ignore req during WAIT and DONE.
REQ-009 au_sub, au_in1 and au_in2 SHALL change only at issue edges and SHALL hold their values otherwise, including in IDLE.
REQ-010 au_cin SHALL be constant 0.
REQ-011 In WAIT, if counter==1 the block SHALL capture au_out, au_cout and au_invalid into rsp_data, rsp_cout and rsp_invalid and enter DONE; otherwise it SHALL decrement the counter.
REQ-012 In DONE, the block SHALL:
- drive rsp_valid[k]=1 for exactly one cycle;
- set last=k;
- return to IDLE unconditionally.
REQ-013 rsp_data, rsp_cout and rsp_invalid SHALL hold until the next capture.
REQ-014 Latency from the IDLE sampling edge to the rsp_valid cycle SHALL be SETTLE+1 cycles. Throughput SHALL be one operation per SETTLE+2 cycles.
REQ-015 At capture, if au_invalid==1, err_sticky[k] SHALL be set. err_clr[j] SHALL clear err_sticky[j] at the next edge. A simultaneous set and clear on the same index SHALL leave the bit set.
REQ-016 The block SHALL pass results through bit-exact, with no rescaling, sign extension or saturation.
REQ-017 gnt and rsp_valid SHALL each have at most one bit set, and SHALL never be high in the same cycle.

Reset
REQ-018 While rst=1, asynchronously:
- state = IDLE;
- last = NREQ-1, so requester 0 wins first;
- counter = 0;
- gnt, rsp_valid, err_sticky, busy, au_sub, au_cin, rsp_cout and rsp_invalid = 0;
- au_in1, au_in2 and rsp_data = 0x0000.
REQ-019 A reset during WAIT or DONE SHALL abandon the operation, with no rsp_valid pulse. After release the block SHALL resume arbitration from requester 0.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Single request: SETTLE=1; req[2]=1, sub=0, a=0x0064, b=0x0032, unit model returns 0x0096 -> gnt[2] 1 cycle after the sampling edge, rsp_valid[2] 2 cycles after it, rsp_data=0x0096, rsp_invalid=0.
- Fairness: req=4'b1111 held, re-raised after each gnt -> grant order 0,1,2,3,0; one gnt every 3 cycles.
- Settle: SETTLE=5; the unit output changes on the 4th WAIT cycle -> the final value is captured; au_in1/au_in2 stable throughout WAIT and DONE.
- Invalid: unit returns au_invalid=1 for requester 1 -> rsp_invalid=1 and err_sticky[1]=1. Same-cycle err_clr[1] and a new invalid -> err_sticky[1] stays 1. A later err_clr[1] alone -> 0.
- Reset mid-operation: rst pulsed during WAIT -> no rsp_valid; all outputs at reset values. A subsequent req=4'b1010 -> gnt[1] first.
- Idle hold: req=0 for 20 cycles after a result -> busy=0; rsp_data and au_in1/au_in2 unchanged.

Source files
------------

// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Round-robin arbiter that shares one external add/sub unit among NREQ
//   requesters. A granted operation is issued to the unit. The unit is given
//   SETTLE cycles to settle. Its result is then captured and returned to the
//   requester that owns it.
//
// Parameters
//   NREQ    number of requester ports
//   SETTLE  settle cycles allowed for the add/sub unit (1..15)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req/sub [NREQ]           request level and subtract select per requester
//   op_a/op_b [16*NREQ]      packed operands, requester k at [16k+15:16k]
//   err_clr [NREQ]           clear strobe for err_sticky
//   gnt [NREQ]               one-cycle acceptance pulse
//   rsp_valid [NREQ]         one-cycle result pulse to the owner
//   rsp_data/cout/invalid    captured unit result, held until next capture
//   err_sticky [NREQ]        sticky invalid flag per requester
//   busy                     high whenever not IDLE
//   au_sub/in1/in2/cin       operation presented to the add/sub unit
//   au_out/cout/invalid      result returned by the add/sub unit
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; arbitrate among req
// WAIT  | operands issued to the unit; count down the settle time
// DONE  | result captured; pulse rsp_valid to the owner, update last
module addsub_arbiter #(
  parameter int NREQ   = 4,
  parameter int SETTLE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      sub,
  input  logic [16*NREQ-1:0]   op_a,
  input  logic [16*NREQ-1:0]   op_b,
  input  logic [NREQ-1:0]      err_clr,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_data,
  output logic                 rsp_cout,
  output logic                 rsp_invalid,
  output logic [NREQ-1:0]      err_sticky,
  output logic                 busy,
  output logic                 au_sub,
  output logic [15:0]          au_in1,
  output logic [15:0]          au_in2,
  output logic                 au_cin,
  input  logic [15:0]          au_out,
  input  logic                 au_cout,
  input  logic                 au_invalid
);

  localparam int          IDXW       = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [3:0]  SETTLE_CNT = 4'(SETTLE);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [IDXW-1:0]   last_q, last_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [NREQ-1:0]   err_sticky_q, err_sticky_d;
  logic              au_sub_q, au_sub_d;
  logic [15:0]       au_in1_q, au_in1_d;
  logic [15:0]       au_in2_q, au_in2_d;
  logic [15:0]       rsp_data_q, rsp_data_d;
  logic              rsp_cout_q, rsp_cout_d;
  logic              rsp_invalid_q, rsp_invalid_d;

  logic [15:0]       op_a_arr [NREQ];
  logic [15:0]       op_b_arr [NREQ];
  logic              pick_found;
  logic [IDXW-1:0]   pick_idx;
  logic [IDXW-1:0]   cand_idx;
  int                cand;
  logic [NREQ-1:0]   pick_oh;
  logic [NREQ-1:0]   owner_oh;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      op_a_arr[k] = op_a[16*k +: 16];
      op_b_arr[k] = op_b[16*k +: 16];
    end
  end

  // Round-robin search starting one past the last served requester.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand     = (int'(last_q) + i) % NREQ;
      cand_idx = IDXW'(cand);
      if (!pick_found && req[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    pick_oh            = '0;
    pick_oh[pick_idx]  = 1'b1;
    owner_oh           = '0;
    owner_oh[owner_q]  = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    gnt_d         = '0;
    rsp_valid_d   = '0;
    au_sub_d      = au_sub_q;
    au_in1_d      = au_in1_q;
    au_in2_d      = au_in2_q;
    rsp_data_d    = rsp_data_q;
    rsp_cout_d    = rsp_cout_q;
    rsp_invalid_d = rsp_invalid_q;
    // A set on the capture edge is applied after the clear, so it wins.
    err_sticky_d  = err_sticky_q & ~err_clr;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          au_sub_d = sub[pick_idx];
          au_in1_d = op_a_arr[pick_idx];
          au_in2_d = op_b_arr[pick_idx];
          cnt_d    = SETTLE_CNT;
          owner_d  = pick_idx;
          gnt_d    = pick_oh;
          state_d  = WAIT;
        end
      end
      WAIT: begin
        // <= 1 rather than == 1 so an out-of-range SETTLE of 0 cannot wrap.
        if (cnt_q <= 4'd1) begin
          rsp_data_d    = au_out;
          rsp_cout_d    = au_cout;
          rsp_invalid_d = au_invalid;
          rsp_valid_d   = owner_oh;
          if (au_invalid) begin
            err_sticky_d[owner_q] = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      last_q        <= IDXW'(NREQ - 1);
      owner_q       <= '0;
      cnt_q         <= '0;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      err_sticky_q  <= '0;
      au_sub_q      <= 1'b0;
      au_in1_q      <= 16'h0000;
      au_in2_q      <= 16'h0000;
      rsp_data_q    <= 16'h0000;
      rsp_cout_q    <= 1'b0;
      rsp_invalid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      err_sticky_q  <= err_sticky_d;
      au_sub_q      <= au_sub_d;
      au_in1_q      <= au_in1_d;
      au_in2_q      <= au_in2_d;
      rsp_data_q    <= rsp_data_d;
      rsp_cout_q    <= rsp_cout_d;
      rsp_invalid_q <= rsp_invalid_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_cout    = rsp_cout_q;
  assign rsp_invalid = rsp_invalid_q;
  assign err_sticky  = err_sticky_q;
  assign busy        = (state_q != IDLE);
  assign au_sub      = au_sub_q;
  assign au_in1      = au_in1_q;
  assign au_in2      = au_in2_q;
  assign au_cin      = 1'b0;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: one instance with SETTLE=1 driven by a
// behavioural add/sub model, one with SETTLE=5 whose unit output the bench
// drives directly. Expected responses are queued at grant and checked at
// rsp_valid.
module tb_addsub_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // SETTLE=1 instance
  logic [3:0]  req, sub, err_clr, gnt, rsp_valid, err_sticky;
  logic [63:0] op_a, op_b;
  logic [15:0] rsp_data, au_in1, au_in2, au_out;
  logic        rsp_cout, rsp_invalid, busy, au_sub, au_cin, au_cout, au_invalid;
  logic        inv_force;

  // SETTLE=5 instance
  logic [3:0]  req5, sub5, err_clr5, gnt5, rsp_valid5, err_sticky5;
  logic [63:0] op_a5, op_b5;
  logic [15:0] rsp_data5, au_in1_5, au_in2_5, au_out5;
  logic        rsp_cout5, rsp_invalid5, busy5, au_sub5, au_cin5, au_cout5, au_invalid5;

  addsub_arbiter #(.NREQ(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .req(req), .sub(sub), .op_a(op_a), .op_b(op_b),
    .err_clr(err_clr), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_cout(rsp_cout), .rsp_invalid(rsp_invalid), .err_sticky(err_sticky),
    .busy(busy), .au_sub(au_sub), .au_in1(au_in1), .au_in2(au_in2),
    .au_cin(au_cin), .au_out(au_out), .au_cout(au_cout), .au_invalid(au_invalid)
  );

  addsub_arbiter #(.NREQ(4), .SETTLE(5)) u_dut5 (
    .clk(clk), .rst(rst), .req(req5), .sub(sub5), .op_a(op_a5), .op_b(op_b5),
    .err_clr(err_clr5), .gnt(gnt5), .rsp_valid(rsp_valid5), .rsp_data(rsp_data5),
    .rsp_cout(rsp_cout5), .rsp_invalid(rsp_invalid5), .err_sticky(err_sticky5),
    .busy(busy5), .au_sub(au_sub5), .au_in1(au_in1_5), .au_in2(au_in2_5),
    .au_cin(au_cin5), .au_out(au_out5), .au_cout(au_cout5), .au_invalid(au_invalid5)
  );

  // Combinational add/sub unit model for the SETTLE=1 instance.
  always_comb begin
    if (au_sub) {au_cout, au_out} = {1'b0, au_in1} - {1'b0, au_in2};
    else        {au_cout, au_out} = {1'b0, au_in1} + {1'b0, au_in2};
    au_invalid = inv_force;
  end

  typedef struct {
    int          idx;
    logic [15:0] data;
    logic        cout;
    logic        inv;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0; sub = '0; op_a = '0; op_b = '0; err_clr = '0; inv_force = 1'b0;
    req5 = '0; sub5 = '0; op_a5 = '0; op_b5 = '0; err_clr5 = '0;
    au_out5 = '0; au_cout5 = 1'b0; au_invalid5 = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = '0; sub = '0; op_a = '0; op_b = '0; err_clr = '0; inv_force = 1'b0;
    req5 = '0; sub5 = '0; op_a5 = '0; op_b5 = '0; err_clr5 = '0;
    au_out5 = '0; au_cout5 = 1'b0; au_invalid5 = 1'b0;
    #2;
    n_tests++;
    if ({gnt, rsp_valid, err_sticky, busy, au_sub, au_cin, rsp_cout, rsp_invalid,
         au_in1, au_in2, rsp_data} !== 63'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", {gnt, rsp_valid, err_sticky, busy,
               au_sub, au_cin, rsp_cout, rsp_invalid, au_in1, au_in2, rsp_data});
    end
    n_tests++;
    if ({gnt5, rsp_valid5, err_sticky5, busy5, au_sub5, au_cin5, rsp_cout5, rsp_invalid5,
         au_in1_5, au_in2_5, rsp_data5} !== 63'd0) begin
      n_fail++;
      $display("FAIL reset_outputs5: got %h want 0", {gnt5, rsp_valid5, err_sticky5, busy5,
               au_sub5, au_cin5, rsp_cout5, rsp_invalid5, au_in1_5, au_in2_5, rsp_data5});
    end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_single;
    exp_t it;
    req = 4'b0100; sub = 4'b0000;
    op_a[47:32] = 16'h0064; op_b[47:32] = 16'h0032;
    tick;
    n_tests++;
    if ({gnt, busy} !== {4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL single_gnt: got gnt=%b busy=%b want gnt=0100 busy=1", gnt, busy);
    end
    sb_q.push_back('{2, 16'h0096, 1'b0, 1'b0});
    req = 4'b0000;
    tick;
    n_tests++;
    if (gnt !== 4'b0000) begin
      n_fail++;
      $display("FAIL single_gnt_width: got gnt=%b want 0000", gnt);
    end
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL single_sb: scoreboard empty");
    end else begin
      it = sb_q.pop_front();
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_cout, rsp_invalid} !==
          {4'b0001 << it.idx, it.data, it.cout, it.inv}) begin
        n_fail++;
        $display("FAIL single_rsp: got v=%b d=%h c=%b i=%b want v=%b d=%h c=%b i=%b",
                 rsp_valid, rsp_data, rsp_cout, rsp_invalid,
                 4'b0001 << it.idx, it.data, it.cout, it.inv);
      end
    end
    tick;
    n_tests++;
    if ({rsp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_end: got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_fairness;
    exp_t it;
    int   last_g;
    do_reset;
    last_g = 0;
    for (int k = 0; k < 4; k++) begin
      op_a[16*k +: 16] = 16'(16'h1000 * (k + 1));
      op_b[16*k +: 16] = 16'(k + 1);
    end
    sub = 4'b0000;
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int t;
      int k;
      k = i % 4;
      t = 0;
      while (gnt === 4'b0000 && t < 8) begin tick; t++; end
      n_tests++;
      if (gnt !== (4'b0001 << k)) begin
        n_fail++;
        $display("FAIL fair_gnt%0d: got %b want %b", i, gnt, 4'b0001 << k);
      end
      if (i > 0) begin
        n_tests++;
        if (cyc - last_g !== 3) begin
          n_fail++;
          $display("FAIL fair_interval%0d: got %0d want 3", i, cyc - last_g);
        end
      end
      last_g = cyc;
      sb_q.push_back('{k, 16'(16'h1000 * (k + 1) + (k + 1)), 1'b0, 1'b0});
      tick;
      t = 0;
      while (rsp_valid === 4'b0000 && t < 8) begin tick; t++; end
      if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL fair_sb%0d: scoreboard empty", i);
      end else begin
        it = sb_q.pop_front();
        n_tests++;
        if ({rsp_valid, rsp_data} !== {4'b0001 << it.idx, it.data}) begin
          n_fail++;
          $display("FAIL fair_rsp%0d: got v=%b d=%h want v=%b d=%h",
                   i, rsp_valid, rsp_data, 4'b0001 << it.idx, it.data);
        end
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_settle;
    exp_t it;
    au_out5 = 16'hdead; au_cout5 = 1'b0; au_invalid5 = 1'b0;
    req5 = 4'b0001; sub5 = 4'b0001;
    op_a5[15:0] = 16'h1234; op_b5[15:0] = 16'h0001;
    tick;
    n_tests++;
    if ({gnt5, au_sub5, au_in1_5, au_in2_5} !== {4'b0001, 1'b1, 16'h1234, 16'h0001}) begin
      n_fail++;
      $display("FAIL settle_issue: got gnt=%b s=%b a=%h b=%h want 0001 1 1234 0001",
               gnt5, au_sub5, au_in1_5, au_in2_5);
    end
    sb_q.push_back('{0, 16'h1233, 1'b1, 1'b0});
    req5 = 4'b0000;
    op_a5[15:0] = 16'hffff; op_b5[15:0] = 16'hffff; sub5 = 4'b0000;
    for (int c = 2; c <= 6; c++) begin
      tick;
      if (c == 4) begin au_out5 = 16'h1233; au_cout5 = 1'b1; end
      n_tests++;
      if ({au_sub5, au_in1_5, au_in2_5} !== {1'b1, 16'h1234, 16'h0001}) begin
        n_fail++;
        $display("FAIL settle_hold_c%0d: got s=%b a=%h b=%h want 1 1234 0001",
                 c, au_sub5, au_in1_5, au_in2_5);
      end
      if (c < 6) begin
        n_tests++;
        if (rsp_valid5 !== 4'b0000) begin
          n_fail++;
          $display("FAIL settle_early_c%0d: got rsp_valid=%b want 0000", c, rsp_valid5);
        end
      end else if (sb_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL settle_sb: scoreboard empty");
      end else begin
        it = sb_q.pop_front();
        n_tests++;
        if ({rsp_valid5, rsp_data5, rsp_cout5, rsp_invalid5} !==
            {4'b0001 << it.idx, it.data, it.cout, it.inv}) begin
          n_fail++;
          $display("FAIL settle_rsp: got v=%b d=%h c=%b i=%b want v=%b d=%h c=%b i=%b",
                   rsp_valid5, rsp_data5, rsp_cout5, rsp_invalid5,
                   4'b0001 << it.idx, it.data, it.cout, it.inv);
        end
      end
    end
    tick;
    n_tests++;
    if ({busy5, rsp_valid5, au_in1_5, au_in2_5} !== {1'b0, 4'b0000, 16'h1234, 16'h0001}) begin
      n_fail++;
      $display("FAIL settle_end: got busy=%b v=%b a=%h b=%h want 0 0000 1234 0001",
               busy5, rsp_valid5, au_in1_5, au_in2_5);
    end
  endtask

  task automatic test_invalid;
    exp_t it;
    int   t;
    tick;
    req = 4'b0010; sub = 4'b0000;
    op_a[31:16] = 16'h7fff; op_b[31:16] = 16'h0001;
    inv_force = 1'b1;
    t = 0;
    while (gnt === 4'b0000 && t < 8) begin tick; t++; end
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL inv_gnt: got %b want 0010", gnt);
    end
    sb_q.push_back('{1, 16'h8000, 1'b0, 1'b1});
    req = 4'b0000;
    t = 0;
    tick;
    while (rsp_valid === 4'b0000 && t < 8) begin tick; t++; end
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL inv_sb: scoreboard empty");
    end else begin
      it = sb_q.pop_front();
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_invalid, err_sticky} !==
          {4'b0001 << it.idx, it.data, it.inv, 4'b0010}) begin
        n_fail++;
        $display("FAIL inv_rsp: got v=%b d=%h i=%b err=%b want v=%b d=%h i=%b err=0010",
                 rsp_valid, rsp_data, rsp_invalid, err_sticky,
                 4'b0001 << it.idx, it.data, it.inv);
      end
    end
    tick;
    // Second invalid result with err_clr[1] asserted on the capture edge.
    req = 4'b0010;
    t = 0;
    while (gnt === 4'b0000 && t < 8) begin tick; t++; end
    req = 4'b0000;
    err_clr = 4'b0010;
    sb_q.push_back('{1, 16'h8000, 1'b0, 1'b1});
    tick;
    err_clr = 4'b0000;
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL inv2_sb: scoreboard empty");
    end else begin
      it = sb_q.pop_front();
      n_tests++;
      if ({rsp_valid, rsp_invalid, err_sticky} !== {4'b0001 << it.idx, it.inv, 4'b0010}) begin
        n_fail++;
        $display("FAIL inv_set_wins: got v=%b i=%b err=%b want v=%b i=%b err=0010",
                 rsp_valid, rsp_invalid, err_sticky, 4'b0001 << it.idx, it.inv);
      end
    end
    inv_force = 1'b0;
    tick;
    tick;
    n_tests++;
    if (err_sticky !== 4'b0010) begin
      n_fail++;
      $display("FAIL inv_sticky_hold: got %b want 0010", err_sticky);
    end
    err_clr = 4'b0010;
    tick;
    err_clr = 4'b0000;
    n_tests++;
    if (err_sticky !== 4'b0000) begin
      n_fail++;
      $display("FAIL inv_clear: got %b want 0000", err_sticky);
    end
  endtask

  task automatic test_reset_mid;
    exp_t it;
    int   t;
    req = 4'b0100; sub = 4'b0000;
    op_a[47:32] = 16'h0011; op_b[47:32] = 16'h0022;
    t = 0;
    while (gnt === 4'b0000 && t < 8) begin tick; t++; end
    n_tests++;
    if ({gnt, busy} !== {4'b0100, 1'b1}) begin
      n_fail++;
      $display("FAIL rmid_gnt: got gnt=%b busy=%b want 0100 1", gnt, busy);
    end
    req = 4'b0000;
    rst = 1'b1;
    #1;
    n_tests++;
    if ({gnt, rsp_valid, err_sticky, busy, au_sub, au_cin, rsp_cout, rsp_invalid,
         au_in1, au_in2, rsp_data} !== 63'd0) begin
      n_fail++;
      $display("FAIL rmid_outputs: got %h want 0", {gnt, rsp_valid, err_sticky, busy,
               au_sub, au_cin, rsp_cout, rsp_invalid, au_in1, au_in2, rsp_data});
    end
    #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_tests++;
      if ({rsp_valid, busy} !== 5'b0) begin
        n_fail++;
        $display("FAIL rmid_quiet%0d: got rsp_valid=%b busy=%b want 0 0", c, rsp_valid, busy);
      end
    end
    req = 4'b1010;
    op_a[31:16] = 16'h0100; op_b[31:16] = 16'h0023;
    t = 0;
    while (gnt === 4'b0000 && t < 8) begin tick; t++; end
    n_tests++;
    if (gnt !== 4'b0010) begin
      n_fail++;
      $display("FAIL rmid_first: got %b want 0010", gnt);
    end
    req = 4'b0000;
    sb_q.push_back('{1, 16'h0123, 1'b0, 1'b0});
    t = 0;
    tick;
    while (rsp_valid === 4'b0000 && t < 8) begin tick; t++; end
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL rmid_sb: scoreboard empty");
    end else begin
      it = sb_q.pop_front();
      n_tests++;
      if ({rsp_valid, rsp_data} !== {4'b0001 << it.idx, it.data}) begin
        n_fail++;
        $display("FAIL rmid_rsp: got v=%b d=%h want v=%b d=%h",
                 rsp_valid, rsp_data, 4'b0001 << it.idx, it.data);
      end
    end
    tick;
  endtask

  task automatic test_idle_hold;
    exp_t it;
    int   t;
    req = 4'b1000; sub = 4'b1000;
    op_a[63:48] = 16'h0aaa; op_b[63:48] = 16'h0555;
    t = 0;
    while (gnt === 4'b0000 && t < 8) begin tick; t++; end
    n_tests++;
    if (gnt !== 4'b1000) begin
      n_fail++;
      $display("FAIL idle_gnt: got %b want 1000", gnt);
    end
    req = 4'b0000;
    sb_q.push_back('{3, 16'h0555, 1'b0, 1'b0});
    t = 0;
    tick;
    while (rsp_valid === 4'b0000 && t < 8) begin tick; t++; end
    if (sb_q.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL idle_sb: scoreboard empty");
    end else begin
      it = sb_q.pop_front();
      n_tests++;
      if ({rsp_valid, rsp_data, rsp_cout} !== {4'b0001 << it.idx, it.data, it.cout}) begin
        n_fail++;
        $display("FAIL idle_rsp: got v=%b d=%h c=%b want v=%b d=%h c=%b",
                 rsp_valid, rsp_data, rsp_cout, 4'b0001 << it.idx, it.data, it.cout);
      end
    end
    tick;
    for (int c = 0; c < 20; c++) begin
      op_a = {$urandom(), $urandom()};
      op_b = {$urandom(), $urandom()};
      sub  = 4'($urandom());
      n_tests++;
      if ({busy, gnt, rsp_valid, au_sub, au_cin, au_in1, au_in2, rsp_data} !==
          {1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0aaa, 16'h0555, 16'h0555}) begin
        n_fail++;
        $display("FAIL idle_hold%0d: got busy=%b g=%b v=%b s=%b cin=%b a=%h b=%h d=%h want 0 0000 0000 1 0 0aaa 0555 0555",
                 c, busy, gnt, rsp_valid, au_sub, au_cin, au_in1, au_in2, rsp_data);
      end
      tick;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_single;
    test_fairness;
    test_settle;
    test_invalid;
    test_reset_mid;
    test_idle_hold;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
